// File: rtl/sr_ctrl.sv
// sr_ctrl: queued set/reset pulse sequencer for an external SR flip-flop.
// Pulses s or r per request, then waits for q_fb confirmation or times out.
module sr_ctrl #(
  parameter int DEPTH   = 4,
  parameter int PULSE_W = 1,
  parameter int TIMEOUT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_op,
  output logic       req_ready,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  input  logic       err_clr,
  output logic       busy,
  output logic       err,
  output logic [7:0] cmd_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_N = CW'(DEPTH);
  localparam logic [3:0] PW_LAST = 4'(PULSE_W - 1);
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT
  } state_t;

  state_t        state;
  logic          op;
  logic [3:0]    cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          mem [DEPTH];
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          head;

  assign full      = (count == FULL_N);
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign head      = mem[rd_ptr];
  assign busy      = (state != S_IDLE) || !empty;

  // Request storage; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_op;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Pulse FSM with registered s/r, confirm counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op        <= 1'b0;
      cnt       <= '0;
      s         <= 1'b0;
      r         <= 1'b0;
      err       <= 1'b0;
      cmd_count <= '0;
    end else begin
      if (err_clr) err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          s   <= 1'b0;
          r   <= 1'b0;
          cnt <= '0;
          if (pop) begin
            op    <= head;
            s     <= head;
            r     <= !head;
            state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt == PW_LAST) begin
            s     <= 1'b0;
            r     <= 1'b0;
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          s <= 1'b0;
          r <= 1'b0;
          if (q_fb == op) begin
            cmd_count <= cmd_count + 8'd1;
            state     <= S_IDLE;
          end else if (cnt == TO_LAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          s     <= 1'b0;
          r     <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sr_ctrl.md
SR_CTRL -- requirements
Module: sr_ctrl

Interface
REQ-001 Parameter DEPTH, default 4: request FIFO depth in entries; power of two, 2..16.
REQ-002 Parameter PULSE_W, default 1: S/R pulse width in clk cycles, 1..15.
REQ-003 Parameter TIMEOUT, default 3: maximum clk cycles to wait for q_fb confirmation, 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_op  input  1  request operation: 1 = set, 0 = reset.
REQ-008 req_ready  output  1  FIFO can accept a request.
REQ-009 s  output  1  set drive to the downstream SR flip-flop.
REQ-010 r  output  1  reset drive to the downstream SR flip-flop.
REQ-011 q_fb  input  1  Q returned from the flip-flop.
REQ-012 err_clr  input  1  clears the sticky error flag.
REQ-013 busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
REQ-014 err  output  1  sticky flag for a confirmation timeout.
REQ-015 cmd_count  output  8  count of confirmed commands.

Function
REQ-016 Accept: a request is pushed when req_valid && req_ready; req_ready = !full.
REQ-017 FIFO order: entries are popped in strict arrival order.
REQ-018 Same-cycle push and pop: when the FIFO is non-full, a push and a pop in the same cycle leave the occupancy unchanged.
REQ-019 Full: when full, req_ready is low and req_valid is ignored; no entry is overwritten.
REQ-020 FSM states: IDLE, DRIVE, WAIT.
REQ-021 IDLE -> DRIVE: taken when the FIFO is non-empty; the head entry is popped in that cycle and latched as op.
REQ-022 DRIVE output: s = op and r = !op, held for exactly PULSE_W cycles.
REQ-023 DRIVE -> WAIT: taken after PULSE_W cycles; s and r are 0 in WAIT.
REQ-024 Forbidden combination: s = r = 1 never occurs in any cycle, including reset and transitions.
REQ-025 s and r are registered outputs, glitch-free.
REQ-026 WAIT confirm: if q_fb == op in any WAIT cycle, cmd_count increments (mod 256, 255 -> 0) and the FSM goes to IDLE.
REQ-027 WAIT timeout: if q_fb != op after TIMEOUT WAIT cycles, err is set to 1, cmd_count is unchanged, the command is dropped, and the FSM goes to IDLE.
REQ-028 Timeout on the final cycle: a match on the last WAIT cycle counts as confirm, not error.
REQ-029 err is sticky: err_clr clears it on the next edge.
REQ-030 err_clr vs. new timeout: if err_clr and a new timeout occur in the same cycle, the timeout wins and err = 1.
REQ-031 Latency: a request accepted into an empty FIFO while in IDLE raises s/r two cycles after acceptance (one edge to push, one edge to pop/enter DRIVE).
REQ-032 busy is combinational from state and FIFO occupancy.

Reset
REQ-033 While rst = 1: s = 0, r = 0, err = 0, cmd_count = 0, FIFO empty, state IDLE, req_ready = 1, busy = 0, all immediately and asynchronously.
REQ-034 Reset mid-DRIVE or mid-WAIT: the in-flight command and all queued entries are discarded; no partial pulse resumes after release.
REQ-035 First acceptance: the first edge with rst = 0 may accept a request.

Verification
REQ-036 Set request: reset, push op=1, then q_fb = 1 one cycle after the s pulse -> s high exactly 1 cycle, r stays 0, cmd_count = 1, err = 0, busy returns to 0.
REQ-037 Back-to-back requests: push set, reset, set with q_fb modelled by a behavioural SR flip-flop -> pulse order s, r, s; cmd_count = 3; never s = r = 1.
REQ-038 Full FIFO: hold the FSM in WAIT, push until req_ready = 0 (4 queued entries) -> a fifth req_valid is not accepted; all 4 are executed in order afterwards.
REQ-039 Timeout: push op=1 with q_fb held at 0 -> err = 1 after 3 WAIT cycles, cmd_count unchanged; err_clr pulse -> err = 0.
REQ-040 Reset mid-operation: assert rst during DRIVE with 2 entries queued -> s and r drop to 0 immediately; after release the FIFO is empty, cmd_count = 0, and no further pulses occur.
REQ-041 Counter wrap: run 256 confirmed commands -> cmd_count wraps to 0.
